// File: rtl/serdiv_sc_pkg.sv
// rtl/serdiv_sc_pkg.sv - shared types and constants for the serdiv_sc issuer
//
// Purpose: issuer FSM state encoding, the registered request record and
// divider opcode constants used by serdiv_sc_issuer and its bench.
// Ports: none (package).
package serdiv_sc_pkg;

  // Transaction id width of the surrounding core's scoreboard.
  localparam int TRANS_ID_BITS = 3;

  // Widest operand the request record can carry; the issuer's WIDTH must not exceed it.
  localparam int SC_MAX_WIDTH = 64;

  localparam logic [1:0] OP_UDIV = 2'd0;
  localparam logic [1:0] OP_DIV  = 2'd1;
  localparam logic [1:0] OP_UREM = 2'd2;
  localparam logic [1:0] OP_REM  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } issuer_state_e;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic [SC_MAX_WIDTH-1:0]  op_a;
    logic [SC_MAX_WIDTH-1:0]  op_b;
    logic [1:0]               opcode;
    logic                     a_label;
    logic                     b_label;
  } issuer_req_t;

endpackage

// File: rtl/serdiv_sc_lat_cnt.sv
// rtl/serdiv_sc_lat_cnt.sv - saturating latency counter with clear and enable
//
// Purpose: counts cycles while en_i is high and sticks at all-ones instead of
// wrapping. clr_i has priority over en_i.
// Ports:
//   clk_i      in   clock
//   rst_i      in   synchronous reset, active-high
//   clr_i      in   clear count to 0
//   en_i       in   increment (saturating)
//   cnt_o      out  current count
//   cnt_inc_o  out  saturating count+1 (what the counter would become)
module serdiv_sc_lat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_inc_o
);

  logic [CNT_W-1:0] cnt_q;

  assign cnt_o     = cnt_q;
  assign cnt_inc_o = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_inc_o;
    end
  end

endmodule

// File: rtl/serdiv_sc_issuer.sv
// rtl/serdiv_sc_issuer.sv - single-outstanding issuer front end for serdiv_sc
//
// Purpose: accepts one labelled divide request, drives the divider input
// handshake, collects result/label/latency and returns them downstream.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   flush_i                      abort in-flight operation (highest priority)
//   req_vld_i/req_rdy_o, req_*   upstream request
//   div_in_vld_o/div_in_rdy_i    divider input handshake, div_* registered request
//   div_flush_o                  divider flush pulse (ISSUE/WAIT only)
//   div_out_vld_i/div_out_rdy_o  divider result handshake, div_id_i/div_res_i/div_res_label_i
//   rsp_vld_o/rsp_rdy_i, rsp_*   downstream response with latency rsp_cycles_o
//   err_id_o                     sticky returned-id mismatch
module serdiv_sc_issuer
  import serdiv_sc_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     req_vld_i,
  output logic                     req_rdy_o,
  input  logic [TRANS_ID_BITS-1:0] req_id_i,
  input  logic [WIDTH-1:0]         req_op_a_i,
  input  logic [WIDTH-1:0]         req_op_b_i,
  input  logic [1:0]               req_opcode_i,
  input  logic                     req_a_label_i,
  input  logic                     req_b_label_i,
  output logic                     div_in_vld_o,
  input  logic                     div_in_rdy_i,
  output logic [TRANS_ID_BITS-1:0] div_id_o,
  output logic [WIDTH-1:0]         div_op_a_o,
  output logic [WIDTH-1:0]         div_op_b_o,
  output logic [1:0]               div_opcode_o,
  output logic                     div_a_label_o,
  output logic                     div_b_label_o,
  output logic                     div_flush_o,
  input  logic                     div_out_vld_i,
  output logic                     div_out_rdy_o,
  input  logic [TRANS_ID_BITS-1:0] div_id_i,
  input  logic [WIDTH-1:0]         div_res_i,
  input  logic                     div_res_label_i,
  output logic                     rsp_vld_o,
  input  logic                     rsp_rdy_i,
  output logic [TRANS_ID_BITS-1:0] rsp_id_o,
  output logic [WIDTH-1:0]         rsp_res_o,
  output logic                     rsp_label_o,
  output logic [CNT_W-1:0]         rsp_cycles_o,
  output logic                     err_id_o
);

  issuer_state_e state_q, state_d;
  issuer_req_t   req_q;

  logic [TRANS_ID_BITS-1:0] rsp_id_q;
  logic [WIDTH-1:0]         rsp_res_q;
  logic                     rsp_label_q;
  logic [CNT_W-1:0]         rsp_cycles_q;
  logic                     err_id_q;

  logic             req_fire;
  logic             in_fire;
  logic             res_fire;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  // Handshake events; flush kills all of them so nothing is captured on a flush cycle.
  assign req_fire = (state_q == IDLE)  && req_vld_i     && !flush_i;
  assign in_fire  = (state_q == ISSUE) && div_in_rdy_i  && !flush_i;
  assign res_fire = (state_q == WAIT)  && div_out_vld_i && !flush_i;

  serdiv_sc_lat_cnt #(
    .CNT_W(CNT_W)
  ) u_lat_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (in_fire),
    .en_i     (state_q == WAIT),
    .cnt_o    (cnt),
    .cnt_inc_o(cnt_inc)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (req_fire) state_d = ISSUE;
      ISSUE: begin
        if (flush_i)           state_d = IDLE;
        else if (div_in_rdy_i) state_d = WAIT;
      end
      WAIT: begin
        if (flush_i)            state_d = IDLE;
        else if (div_out_vld_i) state_d = RESP;
      end
      RESP: begin
        if (flush_i || rsp_rdy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic; everything is held low while reset is asserted.
  always_comb begin
    req_rdy_o     = 1'b0;
    div_in_vld_o  = 1'b0;
    div_out_rdy_o = 1'b0;
    rsp_vld_o     = 1'b0;
    div_flush_o   = 1'b0;
    if (!rst_i) begin
      case (state_q)
        IDLE:  req_rdy_o = !flush_i;
        ISSUE: begin
          div_in_vld_o = 1'b1;
          div_flush_o  = flush_i;
        end
        WAIT: begin
          div_out_rdy_o = 1'b1;
          div_flush_o   = flush_i;
        end
        RESP:  rsp_vld_o = 1'b1;
        default: ;
      endcase
    end
  end

  // Request/response datapath
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q        <= '0;
      rsp_id_q     <= '0;
      rsp_res_q    <= '0;
      rsp_label_q  <= 1'b0;
      rsp_cycles_q <= '0;
      err_id_q     <= 1'b0;
    end else begin
      if (req_fire) begin
        req_q.id      <= req_id_i;
        req_q.op_a    <= SC_MAX_WIDTH'(req_op_a_i);
        req_q.op_b    <= SC_MAX_WIDTH'(req_op_b_i);
        req_q.opcode  <= req_opcode_i;
        req_q.a_label <= req_a_label_i;
        req_q.b_label <= req_b_label_i;
      end
      if (res_fire) begin
        rsp_id_q     <= div_id_i;
        rsp_res_q    <= div_res_i;
        // Label comes straight from the divider; never recomputed from operand labels.
        rsp_label_q  <= div_res_label_i;
        rsp_cycles_q <= cnt_inc;
        if (div_id_i != req_q.id) err_id_q <= 1'b1;
      end
    end
  end

  assign div_id_o      = req_q.id;
  assign div_op_a_o    = req_q.op_a[WIDTH-1:0];
  assign div_op_b_o    = req_q.op_b[WIDTH-1:0];
  assign div_opcode_o  = req_q.opcode;
  assign div_a_label_o = req_q.a_label;
  assign div_b_label_o = req_q.b_label;

  assign rsp_id_o     = rsp_id_q;
  assign rsp_res_o    = rsp_res_q;
  assign rsp_label_o  = rsp_label_q;
  assign rsp_cycles_o = rsp_cycles_q;
  assign err_id_o     = err_id_q;

  // Counter value itself is only observed through cnt_inc.
  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_serdiv_sc_issuer.sv
// tb/tb_serdiv_sc_issuer.sv - directed self-checking bench for serdiv_sc_issuer
module tb_serdiv_sc_issuer;
  import serdiv_sc_pkg::*;

  localparam int WIDTH = 64;
  localparam int CNT_W = 4;

  logic                     clk = 1'b0;
  logic                     rst_i = 1'b1;
  logic                     flush_i = 1'b0;
  logic                     req_vld_i = 1'b0;
  logic                     req_rdy_o;
  logic [TRANS_ID_BITS-1:0] req_id_i = '0;
  logic [WIDTH-1:0]         req_op_a_i = '0;
  logic [WIDTH-1:0]         req_op_b_i = '0;
  logic [1:0]               req_opcode_i = '0;
  logic                     req_a_label_i = 1'b0;
  logic                     req_b_label_i = 1'b0;
  logic                     div_in_vld_o;
  logic                     div_in_rdy_i = 1'b0;
  logic [TRANS_ID_BITS-1:0] div_id_o;
  logic [WIDTH-1:0]         div_op_a_o;
  logic [WIDTH-1:0]         div_op_b_o;
  logic [1:0]               div_opcode_o;
  logic                     div_a_label_o;
  logic                     div_b_label_o;
  logic                     div_flush_o;
  logic                     div_out_vld_i = 1'b0;
  logic                     div_out_rdy_o;
  logic [TRANS_ID_BITS-1:0] div_id_i = '0;
  logic [WIDTH-1:0]         div_res_i = '0;
  logic                     div_res_label_i = 1'b0;
  logic                     rsp_vld_o;
  logic                     rsp_rdy_i = 1'b1;
  logic [TRANS_ID_BITS-1:0] rsp_id_o;
  logic [WIDTH-1:0]         rsp_res_o;
  logic                     rsp_label_o;
  logic [CNT_W-1:0]         rsp_cycles_o;
  logic                     err_id_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serdiv_sc_issuer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_id_i(req_id_i),
    .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i), .req_opcode_i(req_opcode_i),
    .req_a_label_i(req_a_label_i), .req_b_label_i(req_b_label_i),
    .div_in_vld_o(div_in_vld_o), .div_in_rdy_i(div_in_rdy_i), .div_id_o(div_id_o),
    .div_op_a_o(div_op_a_o), .div_op_b_o(div_op_b_o), .div_opcode_o(div_opcode_o),
    .div_a_label_o(div_a_label_o), .div_b_label_o(div_b_label_o), .div_flush_o(div_flush_o),
    .div_out_vld_i(div_out_vld_i), .div_out_rdy_o(div_out_rdy_o), .div_id_i(div_id_i),
    .div_res_i(div_res_i), .div_res_label_i(div_res_label_i),
    .rsp_vld_o(rsp_vld_o), .rsp_rdy_i(rsp_rdy_i), .rsp_id_o(rsp_id_o), .rsp_res_o(rsp_res_o),
    .rsp_label_o(rsp_label_o), .rsp_cycles_o(rsp_cycles_o), .err_id_o(err_id_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [TRANS_ID_BITS-1:0] id, input logic [63:0] a,
                          input logic [63:0] b, input logic [1:0] op,
                          input logic la, input logic lb);
    int n = 0;
    while (!req_rdy_o && n < 50) begin
      step();
      n++;
    end
    check("req_rdy_before_req", {63'd0, req_rdy_o}, 64'd1);
    req_vld_i = 1'b1;
    req_id_i = id; req_op_a_i = a; req_op_b_i = b; req_opcode_i = op;
    req_a_label_i = la; req_b_label_i = lb;
    step();
    req_vld_i = 1'b0;
    check("in_vld_one_cycle_after_req", {63'd0, div_in_vld_o}, 64'd1);
  endtask

  task automatic issue(input int stall, input logic [63:0] exp_a);
    div_in_rdy_i = 1'b0;
    for (int i = 0; i < stall; i++) begin
      check("in_vld_held", {63'd0, div_in_vld_o}, 64'd1);
      check("op_a_held", div_op_a_o, exp_a);
      step();
    end
    check("op_a_at_issue", div_op_a_o, exp_a);
    div_in_rdy_i = 1'b1;
    step();
    div_in_rdy_i = 1'b0;
    check("in_vld_drop", {63'd0, div_in_vld_o}, 64'd0);
    check("out_rdy_in_wait", {63'd0, div_out_rdy_o}, 64'd1);
  endtask

  task automatic result(input int lat, input logic [TRANS_ID_BITS-1:0] id,
                        input logic [63:0] res, input logic lbl);
    for (int i = 0; i < lat - 1; i++) step();
    div_out_vld_i = 1'b1;
    div_id_i = id; div_res_i = res; div_res_label_i = lbl;
    step();
    div_out_vld_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(); step(); step();
    check("rst_req_rdy", {63'd0, req_rdy_o}, 64'd0);
    check("rst_rsp_vld", {63'd0, rsp_vld_o}, 64'd0);
    check("rst_err", {63'd0, err_id_o}, 64'd0);
    check("rst_div_op_a", div_op_a_o, 64'd0);
    rst_i = 1'b0;
    step();
    check("idle_req_rdy", {63'd0, req_rdy_o}, 64'd1);

    // 1: udiv 100/7, labels a=1 b=0, response held one cycle
    rsp_rdy_i = 1'b1;
    send_req(3'd1, 64'd100, 64'd7, OP_UDIV, 1'b1, 1'b0);
    check("t1_a_label", {63'd0, div_a_label_o}, 64'd1);
    issue(0, 64'd100);
    result(3, 3'd1, 64'd14, 1'b1);
    check("t1_rsp_vld", {63'd0, rsp_vld_o}, 64'd1);
    check("t1_rsp_res", rsp_res_o, 64'd14);
    check("t1_rsp_label", {63'd0, rsp_label_o}, 64'd1);
    check("t1_rsp_cycles", {60'd0, rsp_cycles_o}, 64'd3);
    check("t1_rsp_id", {61'd0, rsp_id_o}, 64'd1);
    step();
    check("t1_rsp_vld_one_cycle", {63'd0, rsp_vld_o}, 64'd0);
    check("t1_back_idle", {63'd0, req_rdy_o}, 64'd1);

    // 2: urem 100/7 with 5 stall cycles; divider label 0 forwarded despite secret operands
    send_req(3'd5, 64'd100, 64'd7, OP_UREM, 1'b1, 1'b1);
    check("t2_opcode", {62'd0, div_opcode_o}, 64'd2);
    issue(5, 64'd100);
    check("t2_op_b", div_op_b_o, 64'd7);
    result(2, 3'd5, 64'd2, 1'b0);
    check("t2_rsp_res", rsp_res_o, 64'd2);
    check("t2_rsp_label", {63'd0, rsp_label_o}, 64'd0);
    check("t2_rsp_cycles", {60'd0, rsp_cycles_o}, 64'd2);
    step();

    // 3: flush in WAIT together with a result -> dropped, then div -20/3 = -6
    send_req(3'd4, 64'd50, 64'd5, OP_DIV, 1'b0, 1'b0);
    issue(0, 64'd50);
    step();
    flush_i = 1'b1;
    div_out_vld_i = 1'b1; div_id_i = 3'd4; div_res_i = 64'd10; div_res_label_i = 1'b0;
    #1;
    check("t3_flush_pulse", {63'd0, div_flush_o}, 64'd1);
    step();
    flush_i = 1'b0;
    div_out_vld_i = 1'b0;
    #1;
    check("t3_flush_one_cycle", {63'd0, div_flush_o}, 64'd0);
    check("t3_no_rsp", {63'd0, rsp_vld_o}, 64'd0);
    check("t3_idle", {63'd0, req_rdy_o}, 64'd1);
    step();
    check("t3_still_no_rsp", {63'd0, rsp_vld_o}, 64'd0);
    send_req(3'd6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, OP_DIV, 1'b0, 1'b0);
    issue(0, 64'hFFFF_FFFF_FFFF_FFEC);
    result(4, 3'd6, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
    check("t3_rsp_res", rsp_res_o, 64'hFFFF_FFFF_FFFF_FFFA);
    check("t3_rsp_cycles", {60'd0, rsp_cycles_o}, 64'd4);
    check("t3_err_clear", {63'd0, err_id_o}, 64'd0);
    step();

    // 4: issued id 2, divider returns id 3 -> sticky error
    send_req(3'd2, 64'd9, 64'd3, OP_UDIV, 1'b0, 1'b0);
    issue(0, 64'd9);
    check("t4_err_before", {63'd0, err_id_o}, 64'd0);
    result(1, 3'd3, 64'd3, 1'b0);
    check("t4_err_set", {63'd0, err_id_o}, 64'd1);
    check("t4_rsp_cycles", {60'd0, rsp_cycles_o}, 64'd1);
    step();

    // 5: downstream back-pressure for 10 cycles in RESP
    rsp_rdy_i = 1'b0;
    send_req(3'd7, 64'd81, 64'd9, OP_UDIV, 1'b0, 1'b1);
    issue(0, 64'd81);
    result(2, 3'd7, 64'd9, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("t5_rsp_vld_held", {63'd0, rsp_vld_o}, 64'd1);
      check("t5_rsp_res_held", rsp_res_o, 64'd9);
      check("t5_req_rdy_low", {63'd0, req_rdy_o}, 64'd0);
      step();
    end
    rsp_rdy_i = 1'b1;
    step();
    check("t5_rsp_done", {63'd0, rsp_vld_o}, 64'd0);
    check("t5_idle", {63'd0, req_rdy_o}, 64'd1);
    check("t5_err_sticky", {63'd0, err_id_o}, 64'd1);

    // 6: latency 20 saturates a 4-bit counter; reset mid-WAIT clears everything
    send_req(3'd1, 64'd1000, 64'd10, OP_UDIV, 1'b0, 1'b0);
    issue(0, 64'd1000);
    result(20, 3'd1, 64'd100, 1'b0);
    check("t6_rsp_res", rsp_res_o, 64'd100);
    check("t6_cycles_sat", {60'd0, rsp_cycles_o}, 64'd15);
    step();
    send_req(3'd2, 64'd77, 64'd7, OP_UDIV, 1'b1, 1'b1);
    issue(0, 64'd77);
    step(); step();
    rst_i = 1'b1;
    flush_i = 1'b1;
    #1;
    check("t6_rst_no_flush_pulse", {63'd0, div_flush_o}, 64'd0);
    step();
    flush_i = 1'b0;
    #1;
    check("t6_rst_req_rdy", {63'd0, req_rdy_o}, 64'd0);
    check("t6_rst_in_vld", {63'd0, div_in_vld_o}, 64'd0);
    check("t6_rst_out_rdy", {63'd0, div_out_rdy_o}, 64'd0);
    check("t6_rst_flush", {63'd0, div_flush_o}, 64'd0);
    check("t6_rst_rsp_vld", {63'd0, rsp_vld_o}, 64'd0);
    check("t6_rst_rsp_res", rsp_res_o, 64'd0);
    check("t6_rst_rsp_cycles", {60'd0, rsp_cycles_o}, 64'd0);
    check("t6_rst_rsp_id", {61'd0, rsp_id_o}, 64'd0);
    check("t6_rst_err", {63'd0, err_id_o}, 64'd0);
    check("t6_rst_op_a", div_op_a_o, 64'd0);
    check("t6_rst_a_label", {63'd0, div_a_label_o}, 64'd0);
    rst_i = 1'b0;
    step();
    check("t6_idle_after_rst", {63'd0, req_rdy_o}, 64'd1);
    check("t6_no_rsp_after_rst", {63'd0, rsp_vld_o}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
